delay_fanout: RTL and testbench
===============================

DELAY_FANOUT -- requirements
Module: delay_fanout

Interface
REQ-001 Parameter WIDTH, default 1: data width of the input and of each output channel, range 1..32.
REQ-002 Parameter DEPTH, default 8: number of delay stages, range 2..64; TW = clog2(DEPTH).
REQ-003 Parameter CH, default 3: number of output channels, range 1..8.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  advance enable; 0 freezes the delay line.
REQ-007 din  in  WIDTH  sample captured into stage 0.
REQ-008 din_vld  in  1  qualifies din; travels with the sample.
REQ-009 tap_sel  in  CH*TW  per-channel tap request, channel k in bits [k*TW +: TW].
REQ-010 tap_ld  in  1  loads tap_sel into the tap registers.
REQ-011 dout  out  CH*WIDTH  channel k output in bits [k*WIDTH +: WIDTH].
REQ-012 dout_vld  out  CH  valid bit for each channel.
REQ-013 busy  out  1  high until DEPTH advances have occurred since reset.

Function
REQ-014 Delay line SHALL hold DEPTH stages, each holding data[WIDTH] and vld[1].
REQ-015 On a rising edge with en=1: stage0 <= {din, din_vld}; stage i <= stage i-1 for i=1..DEPTH-1.
REQ-016 On a rising edge with en=0: every stage holds its value and din/din_vld are ignored.
REQ-017 The tap register t_k SHALL be TW bits and load tap_sel field k on the edge where tap_ld=1, independent of en.
REQ-018 A tap request >= DEPTH SHALL be clamped to DEPTH-1 when it is loaded.
REQ-019 Effective index: e_k = t_k.
REQ-020 Outputs are combinational from registered state: dout[k] = stage[e_k].data and dout_vld[k] = stage[e_k].vld.
REQ-021 Latency with en held at 1: a sample presented at edge n appears on channel k after edge n+e_k, i.e. a delay of e_k+1 cycles.
REQ-022 A new tap takes effect on the cycle after the tap_ld edge.
  - No output masking is applied.
  - The stage contents are not disturbed.
REQ-023 A fill counter SHALL count en=1 edges and saturate at DEPTH.
  - busy = (fill counter < DEPTH).
REQ-024 When tap_ld and en are both asserted on the same edge, the shift and the tap load SHALL both occur.
REQ-025 The vld bit SHALL propagate through the stages regardless of its value, so bubbles are preserved.

Reset
REQ-026 While rst_n=0, all stage data and vld bits SHALL be 0.
  - dout = 0, dout_vld = 0.
  - All t_k = 0.
  - Fill counter = 0 and busy = 1.
REQ-027 Reset mid-operation SHALL discard all samples in flight.
  - The first valid output after release follows REQ-021 timing from the first sample captured after release.
REQ-028 Deassertion of rst_n is sampled on clk.
  - The first edge with rst_n=1 may shift the line.

Configuration
REQ-029 Macro DELAY_CASCADE_EN.
  - When defined, e_0 = t_0.
  - When defined, for k>0, e_k = min(e_{k-1} + t_k + 1, DEPTH-1), computed combinationally from the tap registers.
  - Channel k then trails channel k-1 by t_k+1 cycles until saturation.
REQ-030 When DELAY_CASCADE_EN is not defined, e_k = t_k for all k (independent taps) and no cascade logic SHALL be generated.

Verification
REQ-031 Defaults; reset; taps loaded {0,3,7}; en=1; din_vld=1 pulse with din=1 at edge 5.
  - Required: ch0 high after edge 5, ch1 after edge 8, ch2 after edge 12.
  - Required: each high for one cycle with vld=1.
REQ-032 WIDTH=8; taps {2,2,2}; din ramps 0x00..0xFF with en=1.
  - Required: all channels equal to din delayed 3 cycles.
  - Required: busy falls after the 8th en edge.
REQ-033 en toggles 1,0,0,1 while a sample is at stage 1.
  - Required: the sample reaches tap 3 exactly 2 cycles later than with en held at 1.
  - Required: dout is stable during en=0.
REQ-034 DEPTH=6; tap request 7 on ch0.
  - Required: clamped to 5; a sample appears 6 cycles after capture.
REQ-035 rst_n pulled low while three valid samples are in flight.
  - Required: dout=0, dout_vld=0 and busy=1 immediately, before any clock edge.
  - Required: no stale sample appears after release.
REQ-036 DELAY_CASCADE_EN defined; taps {1,2,7}; DEPTH=8.
  - Required: e = {1,4,7} (ch2 saturated).
  - Required: a pulse appears after 2, 5 and 8 cycles on ch0, ch1 and ch2 respectively.

Source files
------------

// File: rtl/delay_fanout.sv
// rtl/delay_fanout.sv - tapped delay line with per-channel selectable output taps
//
// Parameters: WIDTH (sample width), DEPTH (stages), CH (output channels).
// Optional feature macro: DELAY_CASCADE_EN (each channel's tap counts on top of
// the previous channel's effective index instead of being independent).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 advance enable for the delay line and fill counter
//   din, din_vld       sample and qualifier captured into stage 0
//   tap_sel, tap_ld    per-channel tap request, loaded when tap_ld=1
//   dout, dout_vld     per-channel data and valid read from the selected stage
//   busy               high until DEPTH advances have occurred since reset
module delay_fanout #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CH    = 3,
    localparam int TW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    din,
    input  logic                din_vld,
    input  logic [CH*TW-1:0]    tap_sel,
    input  logic                tap_ld,
    output logic [CH*WIDTH-1:0] dout,
    output logic [CH-1:0]       dout_vld,
    output logic                busy
);

    localparam int FW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [TW-1:0]    tap_q      [CH];
    logic [TW-1:0]    eff        [CH];
    logic [FW-1:0]    fill_cnt;

    // Requests beyond the last stage are pinned to the last stage at load time,
    // so the tap registers never hold an out-of-range index.
    function automatic logic [TW-1:0] clamp_tap(input logic [TW-1:0] req);
        if ({1'b0, req} >= (TW+1)'(DEPTH))
            return TW'(DEPTH - 1);
        else
            return req;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                stage_data[i] <= '0;
            stage_vld <= '0;
        end else if (en) begin
            stage_data[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stage_data[i] <= stage_data[i-1];
            // vld shifts unconditionally so bubbles keep their position
            stage_vld <= {stage_vld[DEPTH-2:0], din_vld};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++)
                tap_q[k] <= '0;
        end else if (tap_ld) begin
            for (int k = 0; k < CH; k++)
                tap_q[k] <= clamp_tap(tap_sel[k*TW +: TW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill_cnt <= '0;
        else if (en && (fill_cnt < FW'(DEPTH)))
            fill_cnt <= fill_cnt + FW'(1);
    end

    assign busy = (fill_cnt < FW'(DEPTH));

`ifdef DELAY_CASCADE_EN
    // Channel k sits t_k+1 stages behind channel k-1, saturating at the last stage.
    function automatic logic [TW-1:0] cascade_step(input logic [TW-1:0] prev,
                                                   input logic [TW-1:0] t);
        logic [TW+1:0] s;
        s = {2'b00, prev} + {2'b00, t} + (TW+2)'(1);
        if (s > (TW+2)'(DEPTH - 1))
            return TW'(DEPTH - 1);
        else
            return s[TW-1:0];
    endfunction

    always_comb begin
        eff[0] = tap_q[0];
        for (int k = 1; k < CH; k++)
            eff[k] = cascade_step(eff[k-1], tap_q[k]);
    end
`else
    always_comb begin
        for (int k = 0; k < CH; k++)
            eff[k] = tap_q[k];
    end
`endif

    always_comb begin
        dout     = '0;
        dout_vld = '0;
        for (int k = 0; k < CH; k++) begin
            dout[k*WIDTH +: WIDTH] = stage_data[eff[k]];
            dout_vld[k]            = stage_vld[eff[k]];
        end
    end

endmodule

// File: tb/tb_delay_fanout.sv
// tb/tb_delay_fanout.sv - self-checking bench for delay_fanout
module tb_delay_fanout;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int C  = 3;
    localparam int TW = 3;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [W-1:0]   din;
    logic           din_vld;
    logic [C*TW-1:0] tap_sel;
    logic           tap_ld;
    logic [C*W-1:0] dout;
    logic [C-1:0]   dout_vld;
    logic           busy;

    // second instance: DEPTH=6 single channel, used for tap clamping
    logic           en2;
    logic [W-1:0]   din2;
    logic           vld2;
    logic [2:0]     tsel2;
    logic           tld2;
    logic [W-1:0]   dout2;
    logic [0:0]     dout2_vld;
    logic           busy2;

    int n_tests = 0;
    int n_fail  = 0;

    delay_fanout #(.WIDTH(W), .DEPTH(D), .CH(C)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_vld(din_vld),
        .tap_sel(tap_sel), .tap_ld(tap_ld), .dout(dout), .dout_vld(dout_vld),
        .busy(busy)
    );

    delay_fanout #(.WIDTH(W), .DEPTH(6), .CH(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .din(din2), .din_vld(vld2),
        .tap_sel(tsel2), .tap_ld(tld2), .dout(dout2), .dout_vld(dout2_vld),
        .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Every captured sample since reset is kept; stage i holds the sample
    // captured i advances ago, or zero if fewer samples exist.
    logic [W-1:0] cap_d[$];
    bit           cap_v[$];
    int           m_tap[C];

    function automatic int m_eff(int k);
        int e;
        e = m_tap[0];
`ifdef DELAY_CASCADE_EN
        for (int j = 1; j <= k; j++) begin
            e = e + m_tap[j] + 1;
            if (e > D - 1) e = D - 1;
        end
`else
        e = m_tap[k];
`endif
        return e;
    endfunction

    task automatic model_reset();
        cap_d.delete();
        cap_v.delete();
        for (int k = 0; k < C; k++) m_tap[k] = 0;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        logic [C*W-1:0] ed;
        logic [C-1:0]   ev;
        int n;
        int e;
        n  = cap_d.size();
        ed = '0;
        ev = '0;
        for (int k = 0; k < C; k++) begin
            e = m_eff(k);
            if (e < n) begin
                ed[k*W +: W] = cap_d[n-1-e];
                ev[k]        = cap_v[n-1-e];
            end
        end
        cmp({tag, "_dout"}, 64'(dout), 64'(ed));
        cmp({tag, "_vld"},  64'(dout_vld), 64'(ev));
        cmp({tag, "_busy"}, 64'(busy), 64'(n < D));
    endtask

    // One clock: drive inputs, take the edge, update the model, check at edge+1.
    task automatic step(input bit e, input logic [W-1:0] d, input bit v,
                        input bit ld, input logic [C*TW-1:0] ts, input string tag);
        int t;
        en      = e;
        din     = d;
        din_vld = v;
        tap_ld  = ld;
        tap_sel = ts;
        @(posedge clk);
        if (ld) begin
            for (int k = 0; k < C; k++) begin
                t = int'(ts[k*TW +: TW]);
                m_tap[k] = (t >= D) ? D - 1 : t;
            end
        end
        if (e) begin
            cap_d.push_back(d);
            cap_v.push_back(v);
        end
        #1;
        model_check(tag);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0; din = '0; din_vld = 1'b0; tap_ld = 1'b0; tap_sel = '0;
        en2     = 1'b0; din2 = '0; vld2 = 1'b0; tld2 = 1'b0; tsel2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_check("reset");
        rst_n = 1'b1;
    endtask

    // ---------------- pulse table ----------------
    typedef struct {
        bit           en;
        logic [W-1:0] din;
        bit           vld;
        bit           ld;
        logic [C*W-1:0] exp_dout;
        logic [C-1:0] exp_vld;
        bit           exp_busy;
    } vec_t;

    vec_t tbl[14];

`ifdef DELAY_CASCADE_EN
    localparam logic [C*TW-1:0] TBL_TAPS = {3'd7, 3'd2, 3'd1};
    localparam int P0 = 6, P1 = 9, P2 = 12;
`else
    localparam logic [C*TW-1:0] TBL_TAPS = {3'd7, 3'd3, 3'd0};
    localparam int P0 = 5, P1 = 8, P2 = 12;
`endif

    initial begin
        logic [C*TW-1:0] ts;
        logic [W-1:0]    rd;
        int              p;

        for (int n = 1; n <= 14; n++) begin
            tbl[n-1].en       = 1'b1;
            tbl[n-1].din      = (n == 5) ? 8'h01 : 8'h00;
            tbl[n-1].vld      = (n == 5);
            tbl[n-1].ld       = (n == 1);
            tbl[n-1].exp_dout = {(n == P2) ? 8'h01 : 8'h00,
                                 (n == P1) ? 8'h01 : 8'h00,
                                 (n == P0) ? 8'h01 : 8'h00};
            tbl[n-1].exp_vld  = {n == P2, n == P1, n == P0};
            tbl[n-1].exp_busy = (n < 8);
        end

        // pulse through the three taps
        do_reset();
        for (int n = 0; n < 14; n++) begin
            step(tbl[n].en, tbl[n].din, tbl[n].vld, tbl[n].ld, TBL_TAPS, "tbl_model");
            cmp($sformatf("tbl%0d_dout", n + 1), 64'(dout), 64'(tbl[n].exp_dout));
            cmp($sformatf("tbl%0d_vld", n + 1), 64'(dout_vld), 64'(tbl[n].exp_vld));
            cmp($sformatf("tbl%0d_busy", n + 1), 64'(busy), 64'(tbl[n].exp_busy));
        end

        // ramp with tap 2 on every channel: ch0 is din delayed three cycles
        do_reset();
        ts = {3'd2, 3'd2, 3'd2};
        for (int i = 1; i <= 260; i++) begin
            rd = W'(i - 1);
            step(1'b1, rd, 1'b1, i == 1, ts, "ramp");
            if (i >= 3) cmp($sformatf("ramp%0d_ch0", i), 64'(dout[W-1:0]), 64'((i - 3) & 8'hFF));
            if (i == 7 || i == 8) cmp($sformatf("ramp%0d_busy", i), 64'(busy), 64'(i < 8));
        end

        // stall: en 1,0,0,1 while the pulse sits in stage 1, ch0 tap 3
        do_reset();
        ts = {3'd3, 3'd3, 3'd3};
        step(1'b1, 8'h00, 1'b0, 1'b1, ts, "stall_ld");
        p = 0;
        for (int j = 0; j <= 6; j++) begin
            step(!(j == 3 || j == 4), (j == 0) ? 8'h5A : 8'h00, j == 0, 1'b0, ts, "stall");
            cmp($sformatf("stall%0d_ch0", j), 64'(dout[W-1:0]), 64'((j == 5) ? 8'h5A : 8'h00));
            cmp($sformatf("stall%0d_v0", j), 64'(dout_vld[0]), 64'(j == 5));
        end

        // clamp: DEPTH=6, request 7 becomes 5, sample appears 6 cycles after capture
        do_reset();
        for (int j = 1; j <= 10; j++) begin
            en2   = 1'b1;
            tld2  = (j == 1);
            tsel2 = 3'd7;
            din2  = (j == 2) ? 8'hA5 : 8'h00;
            vld2  = (j == 2);
            @(posedge clk);
            #1;
            if (j >= 2) begin
                cmp($sformatf("clamp%0d_dout", j), 64'(dout2), 64'((j == 7) ? 8'hA5 : 8'h00));
                cmp($sformatf("clamp%0d_vld", j), 64'(dout2_vld), 64'(j == 7));
            end
        end
        en2 = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom),
                 (i == 0) || ($urandom_range(0, 15) == 0), (C*TW)'($urandom), "rand");
        end

        // reset while valid samples are in flight
        do_reset();
        ts = {3'd5, 3'd3, 3'd1};
        step(1'b1, 8'h00, 1'b0, 1'b1, ts, "mid_ld");
        step(1'b1, 8'h11, 1'b1, 1'b0, ts, "mid_a");
        step(1'b1, 8'h22, 1'b1, 1'b0, ts, "mid_b");
        step(1'b1, 8'h33, 1'b1, 1'b0, ts, "mid_c");
        step(1'b1, 8'h00, 1'b0, 1'b0, ts, "mid_d");
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_dout", 64'(dout), 64'(0));
        cmp("mid_rst_vld",  64'(dout_vld), 64'(0));
        cmp("mid_rst_busy", 64'(busy), 64'(1));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < D + 4; i++) begin
            step(1'b1, W'($urandom), 1'b0, 1'b0, ts, "post_rst");
            cmp($sformatf("post_rst%0d_vld", i), 64'(dout_vld), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
